instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue_if.sv | 42 ++++
 rtl/instr_queue.sv | 151 +++++++++++++++
 tb/tb_instr_queue.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_queue_if.sv
// Handshake bundle between the instruction queue, the fetch cache (fc),
// the reorder buffer (rob) and the dispatch stage (dc).
interface instr_queue_if;
    logic        is_exception_from_rob;
    logic [31:0] pc_from_rob;
    logic        is_ready_from_rob;
    logic        is_finish_from_fc;
    logic [31:0] instr_from_fc;
    logic        is_request_to_fc;
    logic [31:0] pc_to_fc;
    logic        is_empty_to_dc;
    logic [31:0] instr_to_dc;
    logic [31:0] pc_to_dc;

    // The queue itself.
    modport slave (
        input  is_exception_from_rob,
        input  pc_from_rob,
        input  is_ready_from_rob,
        input  is_finish_from_fc,
        input  instr_from_fc,
        output is_request_to_fc,
        output pc_to_fc,
        output is_empty_to_dc,
        output instr_to_dc,
        output pc_to_dc
    );

    // The surrounding pipeline driving the queue.
    modport master (
        output is_exception_from_rob,
        output pc_from_rob,
        output is_ready_from_rob,
        output is_finish_from_fc,
        output instr_from_fc,
        input  is_request_to_fc,
        input  pc_to_fc,
        input  is_empty_to_dc,
        input  instr_to_dc,
        input  pc_to_dc
    );
endinterface

// File: rtl/instr_queue.sv
// Instruction queue: fetches sequential instructions one at a time from the
// fetch cache into a circular FIFO and dispatches them one per cycle to the
// decode stage. A ROB exception flushes the queue and redirects fetch.
// All outputs are registered.
module instr_queue #(
    parameter int unsigned BufferLength  = 16,
    parameter int unsigned PointerLength = 3,
    parameter logic [31:0] ResetPc       = 32'h0
) (
    input logic         clk,
    input logic         rst,
    instr_queue_if.slave bus
);

    localparam int unsigned PtrW = PointerLength + 1;
    localparam int unsigned CntW = PointerLength + 2;
    localparam logic [CntW-1:0] FullCount = CntW'(BufferLength);

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            req_q, req_d;
    logic [31:0]     pc_fc_q, pc_fc_d;
    logic            empty_q, empty_d;
    logic [31:0]     instr_dc_q, instr_dc_d;
    logic [31:0]     pc_dc_q, pc_dc_d;

    logic [31:0] pc_mem_q    [BufferLength];
    logic [31:0] instr_mem_q [BufferLength];

    logic exc;
    logic do_write;
    logic do_disp;

    // Qualified write/dispatch strobes; an exception suppresses both.
    always_comb begin
        exc      = bus.is_exception_from_rob;
        do_write = (state_q == StWait) && bus.is_finish_from_fc && !exc;
        do_disp  = (count_q != '0) && bus.is_ready_from_rob && !exc;
    end

    // Fetch FSM, pointer/count bookkeeping and registered output values.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = 1'b0;
        pc_fc_d    = pc_fc_q;
        empty_d    = 1'b1;
        instr_dc_d = instr_dc_q;
        pc_dc_d    = pc_dc_q;

        unique case (state_q)
            StIdle: begin
                // Only request when a slot is free, so a return never overflows.
                if (!exc && (count_q < FullCount)) begin
                    state_d = StWait;
                    req_d   = 1'b1;
                    pc_fc_d = fetch_pc_q;
                end
            end
            StWait: begin
                // A return coinciding with an exception is dropped here.
                if (bus.is_finish_from_fc) begin
                    state_d = StIdle;
                end else if (exc) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (bus.is_finish_from_fc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_write) begin
            tail_d     = tail_q + PtrW'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (do_disp) begin
            head_d     = head_q + PtrW'(1);
            empty_d    = 1'b0;
            instr_dc_d = instr_mem_q[head_q];
            pc_dc_d    = pc_mem_q[head_q];
        end

        case ({do_write, do_disp})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (exc) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = bus.pc_from_rob;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fetch_pc_q <= ResetPc;
            req_q      <= 1'b0;
            pc_fc_q    <= '0;
            empty_q    <= 1'b1;
            instr_dc_q <= '0;
            pc_dc_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            pc_fc_q    <= pc_fc_d;
            empty_q    <= empty_d;
            instr_dc_q <= instr_dc_d;
            pc_dc_q    <= pc_dc_d;
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (do_write) begin
            pc_mem_q[tail_q]    <= fetch_pc_q;
            instr_mem_q[tail_q] <= bus.instr_from_fc;
        end
    end

    assign bus.is_request_to_fc = req_q;
    assign bus.pc_to_fc         = pc_fc_q;
    assign bus.is_empty_to_dc   = empty_q;
    assign bus.instr_to_dc      = instr_dc_q;
    assign bus.pc_to_dc         = pc_dc_q;

endmodule

// File: tb/tb_instr_queue.sv
// Directed testbench for instr_queue.
module tb_instr_queue;

    localparam logic [31:0] TagBase = 32'hA000_0000;
    localparam logic [31:0] Nop     = 32'h0000_0013;
    localparam logic [31:0] Bad     = 32'hDEAD_BEEF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    instr_queue_if bus ();

    instr_queue #(
        .BufferLength  (16),
        .PointerLength (3),
        .ResetPc       (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.is_exception_from_rob = 1'b0;
        bus.pc_from_rob           = '0;
        bus.is_ready_from_rob     = 1'b0;
        bus.is_finish_from_fc     = 1'b0;
        bus.instr_from_fc         = '0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        chk1 ("rst_req",      bus.is_request_to_fc, 1'b0);
        chk32("rst_pc_fc",    bus.pc_to_fc,         32'h0);
        chk1 ("rst_empty",    bus.is_empty_to_dc,   1'b1);
        chk32("rst_instr_dc", bus.instr_to_dc,      32'h0);
        chk32("rst_pc_dc",    bus.pc_to_dc,         32'h0);
        @(posedge clk);
        #3 rst = 1'b1;

        // Basic flow: fc answers two cycles after each request, ROB ready.
        bus.is_ready_from_rob = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1 ($sformatf("flow_req%0d", k), bus.is_request_to_fc, 1'b1);
            chk32($sformatf("flow_pcfc%0d", k), bus.pc_to_fc, 32'(4 * k));
            if (k > 0) begin
                chk1 ($sformatf("flow_empty%0d", k), bus.is_empty_to_dc, 1'b0);
                chk32($sformatf("flow_pcdc%0d", k), bus.pc_to_dc, 32'(4 * (k - 1)));
                chk32($sformatf("flow_instr%0d", k), bus.instr_to_dc, Nop);
            end
            tick();
            chk1 ($sformatf("flow_reqlow%0d", k), bus.is_request_to_fc, 1'b0);
            bus.is_finish_from_fc = 1'b1;
            bus.instr_from_fc     = Nop;
            tick();
            chk1 ($sformatf("flow_nobypass%0d", k), bus.is_empty_to_dc, 1'b1);
            bus.is_finish_from_fc = 1'b0;
        end
        tick();
        chk1 ("flow_req3",   bus.is_request_to_fc, 1'b1);
        chk32("flow_pcfc3",  bus.pc_to_fc,         32'd12);
        chk1 ("flow_empty3", bus.is_empty_to_dc,   1'b0);
        chk32("flow_pcdc3",  bus.pc_to_dc,         32'd8);

        // Exception while waiting; the late return must be discarded.
        bus.is_exception_from_rob = 1'b1;
        bus.pc_from_rob           = 32'h100;
        tick();
        chk1("exc_req",   bus.is_request_to_fc, 1'b0);
        chk1("exc_empty", bus.is_empty_to_dc,   1'b1);
        bus.is_exception_from_rob = 1'b0;
        bus.is_finish_from_fc     = 1'b1;
        bus.instr_from_fc         = Bad;
        tick();
        chk1("disc_req", bus.is_request_to_fc, 1'b0);
        bus.is_finish_from_fc = 1'b0;
        tick();
        chk1 ("redir_req",   bus.is_request_to_fc, 1'b1);
        chk32("redir_pcfc",  bus.pc_to_fc,         32'h100);
        chk1 ("redir_empty", bus.is_empty_to_dc,   1'b1);
        tick();
        chk1("redir_empty2", bus.is_empty_to_dc,   1'b1);
        chk1("redir_reqlow", bus.is_request_to_fc, 1'b0);

        // Reset between edges while a fetch is outstanding.
        #3 rst = 1'b0;
        #1;
        chk1 ("mrst_req",      bus.is_request_to_fc, 1'b0);
        chk32("mrst_pc_fc",    bus.pc_to_fc,         32'h0);
        chk1 ("mrst_empty",    bus.is_empty_to_dc,   1'b1);
        chk32("mrst_instr_dc", bus.instr_to_dc,      32'h0);
        chk32("mrst_pc_dc",    bus.pc_to_dc,         32'h0);
        bus.is_finish_from_fc = 1'b1;
        bus.instr_from_fc     = Bad;
        tick();
        chk1("mrst_hold_req", bus.is_request_to_fc, 1'b0);
        #3 rst = 1'b1;
        tick();
        chk1 ("mrst_first_req", bus.is_request_to_fc, 1'b1);
        chk32("mrst_first_pc",  bus.pc_to_fc,         32'h0);
        bus.is_finish_from_fc = 1'b0;

        // Fill to 16 entries with the ROB stalled.
        bus.is_ready_from_rob = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.is_finish_from_fc = 1'b1;
            bus.instr_from_fc     = TagBase + 32'(i);
            tick();
            bus.is_finish_from_fc = 1'b0;
            chk1($sformatf("fill_reqlow%0d", i), bus.is_request_to_fc, 1'b0);
            chk1($sformatf("fill_empty%0d", i),  bus.is_empty_to_dc,   1'b1);
            tick();
            if (i < 15) begin
                chk1 ($sformatf("fill_req%0d", i),  bus.is_request_to_fc, 1'b1);
                chk32($sformatf("fill_pcfc%0d", i), bus.pc_to_fc,         32'(4 * (i + 1)));
            end else begin
                chk1("full_noreq", bus.is_request_to_fc, 1'b0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1($sformatf("full_hold_req%0d", i),   bus.is_request_to_fc, 1'b0);
            chk1($sformatf("full_hold_empty%0d", i), bus.is_empty_to_dc,   1'b1);
        end

        // Drain with concurrent refills; head and tail both wrap.
        bus.is_ready_from_rob = 1'b1;
        for (int k = 0; k < 28; k++) begin
            if (k >= 2 && (k % 2) == 0) begin
                bus.is_finish_from_fc = 1'b1;
                bus.instr_from_fc     = TagBase + 32'(16 + (k - 2) / 2);
            end else begin
                bus.is_finish_from_fc = 1'b0;
            end
            tick();
            chk1 ($sformatf("drain_empty%0d", k), bus.is_empty_to_dc,   1'b0);
            chk32($sformatf("drain_pc%0d", k),    bus.pc_to_dc,         32'(4 * k));
            chk32($sformatf("drain_instr%0d", k), bus.instr_to_dc,      TagBase + 32'(k));
            chk1 ($sformatf("drain_req%0d", k),   bus.is_request_to_fc, (k % 2) == 1);
        end
        bus.is_finish_from_fc = 1'b0;

        // Build count=5 with the ROB stalled, then flush on a dispatch edge.
        bus.is_ready_from_rob = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.is_finish_from_fc = 1'b1;
            bus.instr_from_fc     = TagBase + 32'(29 + j);
            tick();
            bus.is_finish_from_fc = 1'b0;
            chk1 ($sformatf("c5_empty%0d", j),  bus.is_empty_to_dc, 1'b1);
            chk32($sformatf("c5_pchold%0d", j), bus.pc_to_dc,       32'd108);
            tick();
            chk1 ($sformatf("c5_req%0d", j),  bus.is_request_to_fc, 1'b1);
            chk32($sformatf("c5_pcfc%0d", j), bus.pc_to_fc,         32'(120 + 4 * j));
        end
        bus.is_ready_from_rob     = 1'b1;
        bus.is_exception_from_rob = 1'b1;
        bus.pc_from_rob           = 32'h200;
        tick();
        chk1("flush_empty", bus.is_empty_to_dc,   1'b1);
        chk1("flush_req",   bus.is_request_to_fc, 1'b0);
        bus.is_exception_from_rob = 1'b0;
        tick();
        chk1("flush_empty_after", bus.is_empty_to_dc,   1'b1);
        tick();
        chk1("flush_disc_req",    bus.is_request_to_fc, 1'b0);
        chk1("flush_disc_empty",  bus.is_empty_to_dc,   1'b1);
        bus.is_finish_from_fc = 1'b1;
        bus.instr_from_fc     = Bad;
        tick();
        chk1("flush_drop_req",   bus.is_request_to_fc, 1'b0);
        chk1("flush_drop_empty", bus.is_empty_to_dc,   1'b1);
        bus.is_finish_from_fc = 1'b0;
        tick();
        chk1 ("flush_redir_req",   bus.is_request_to_fc, 1'b1);
        chk32("flush_redir_pcfc",  bus.pc_to_fc,         32'h200);
        chk1 ("flush_redir_empty", bus.is_empty_to_dc,   1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
